// File: rtl/mult_pkg.sv
// Shared definitions for the sign-magnitude multiplier sequencer and related
// arithmetic stages.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_HOLD  = 2'd3
    } mult_state_e;

    localparam int OPERAND_W     = 8;
    localparam int PRODUCT_W     = 16;
    localparam int OP_SIGN_BIT   = OPERAND_W - 1;
    localparam int PROD_SIGN_BIT = PRODUCT_W - 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sm_normalize.sv
// Combinational sign-magnitude normaliser: removes negative zero and optionally
// converts to two's complement.
module sm_normalize #(
    parameter int W    = 16,
    parameter bit TWOS = 1'b0
) (
    input  logic [W-1:0] sm_in,
    output logic [W-1:0] norm_out
);

    logic [W-2:0] mag;
    logic [W-2:0] mag_inv;
    logic         sgn;

    assign mag = sm_in[W-2:0];
    // A zero magnitude always reads as +0, whatever the incoming sign bit.
    assign sgn = sm_in[W-1] & (|mag);

    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_inv
            assign mag_inv[gi] = ~mag[gi];
        end

        if (TWOS) begin : g_twos
            assign norm_out = sgn ? ({1'b1, mag_inv} + W'(1)) : {1'b0, mag};
        end else begin : g_signmag
            assign norm_out = {sgn, mag};
        end
    endgenerate

endmodule

// File: rtl/mult_sequencer.sv
// Valid/ready front and back end for the 8x8 shift-and-add multiplier, with a
// watchdog that turns a hung multiplier into an error result.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 31,
    parameter bit OUT_TWOS   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_a,
    input  logic [OPERAND_W-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PRODUCT_W-1:0] out_z,
    output logic                 out_err,
    output logic [OPERAND_W-1:0] mul_w,
    output logic [OPERAND_W-1:0] mul_y,
    output logic                 mul_nrst,
    input  logic [PRODUCT_W-1:0] mul_z,
    input  logic                 mul_finish
);

    localparam int              CNT_MAX  = max_int(CLR_CYCLES, TIMEOUT);
    localparam int              CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);

    mult_state_e          state_reg,   state_next;
    logic [CNT_W-1:0]     cnt_reg,     cnt_next;
    logic [OPERAND_W-1:0] mul_w_reg,   mul_w_next;
    logic [OPERAND_W-1:0] mul_y_reg,   mul_y_next;
    logic [PRODUCT_W-1:0] out_z_reg,   out_z_next;
    logic                 out_err_reg, out_err_next;

    logic [CNT_W-1:0]     cnt_inc;
    logic [PRODUCT_W-1:0] norm_z;

    sm_normalize #(
        .W    (PRODUCT_W),
        .TWOS (OUT_TWOS)
    ) u_norm (
        .sm_in    (mul_z),
        .norm_out (norm_z)
    );

    // Counter saturates rather than wrapping.
    assign cnt_inc = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CNT_W'(1);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        mul_w_next   = mul_w_reg;
        mul_y_next   = mul_y_reg;
        out_z_next   = out_z_reg;
        out_err_next = out_err_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    mul_w_next = in_a;
                    mul_y_next = in_b;
                    cnt_next   = '0;
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (cnt_reg == CLR_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_RUN: begin
                cnt_next = cnt_inc;
                // A finish in the final watchdog cycle still yields a real result.
                if (mul_finish) begin
                    out_z_next   = norm_z;
                    out_err_next = 1'b0;
                    state_next   = ST_HOLD;
                end else if (cnt_reg == RUN_LAST) begin
                    out_z_next   = '0;
                    out_err_next = 1'b1;
                    state_next   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            mul_w_reg   <= '0;
            mul_y_reg   <= '0;
            out_z_reg   <= '0;
            out_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            mul_w_reg   <= mul_w_next;
            mul_y_reg   <= mul_y_next;
            out_z_reg   <= out_z_next;
            out_err_reg <= out_err_next;
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_HOLD);
    assign mul_nrst  = (state_reg == ST_RUN);
    assign out_z     = out_z_reg;
    assign out_err   = out_err_reg;
    assign mul_w     = mul_w_reg;
    assign mul_y     = mul_y_reg;

endmodule
